// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store formatter with req/ack handshake to a 64-bit data memory
module mem_access_unit #(
  parameter int N  = 64,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memreadM,
  input  logic          memwriteM,
  input  logic [1:0]    sizeM,
  input  logic          signedM,
  input  logic [N-1:0]  addrM,
  input  logic [N-1:0]  wdataM,
  output logic [N-1:0]  rdataM,
  output logic          stallM,
  output logic          misalign,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_be,
  output logic [63:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [63:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [2:0] off, off_q;
  logic [1:0] size_q;
  logic sgn_q, access, aligned, start, unused_hi;
  logic [7:0] mask;
  logic [63:0] sh, ld;
  assign off = addrM[2:0];
  assign access = memreadM | memwriteM;
  assign aligned = sizeM == 2'b11 ? off == 3'd0 :
                   sizeM == 2'b10 ? off[1:0] == 2'd0 :
                   sizeM == 2'b01 ? !off[0] : 1'b1;
  assign start = state == IDLE && access && aligned;
  assign mask = sizeM == 2'b11 ? 8'hFF : sizeM == 2'b10 ? 8'h0F : sizeM == 2'b01 ? 8'h03 : 8'h01;
  assign unused_hi = ^addrM[N-1:AW];
  // Load formatting uses the offset/size latched at launch, so it is independent of the live M-stage inputs.
  assign sh = mem_rdata >> {off_q, 3'b000};
  assign ld = size_q == 2'b00 ? {{56{sgn_q & sh[7]}}, sh[7:0]} :
              size_q == 2'b01 ? {{48{sgn_q & sh[15]}}, sh[15:0]} :
              size_q == 2'b10 ? {{32{sgn_q & sh[31]}}, sh[31:0]} : sh;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? WAIT : IDLE) :
              state == WAIT ? (mem_ack ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    stallM = (reset && start) || state == WAIT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdataM    <= '0;
      misalign  <= 1'b0;
      off_q     <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
    end else begin
      misalign <= state == IDLE && access && !aligned;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= memwriteM;
        mem_addr  <= {addrM[AW-1:3], 3'b000};
        mem_be    <= mask << off;
        mem_wdata <= wdataM << {off, 3'b000};
        off_q     <= off;
        size_q    <= sizeM;
        sgn_q     <= signedM;
      end else if (state == WAIT && mem_ack) begin
        mem_req <= 1'b0;
        mem_be  <= '0;
        if (!mem_we) rdataM <= ld;
      end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store/handshake checks for mem_access_unit
module tb_mem_access_unit;
  logic clk = 0, reset = 0, memreadM = 0, memwriteM = 0, signedM = 0, mem_ack = 0;
  logic [1:0] sizeM = 0;
  logic [63:0] addrM = 0, wdataM = 0, mem_rdata = 0, rdataM, mem_wdata;
  logic stallM, misalign, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [7:0] mem_be;
  int n_chk = 0, n_fail = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM), .sizeM(sizeM),
    .signedM(signedM), .addrM(addrM), .wdataM(wdataM), .rdataM(rdataM), .stallM(stallM),
    .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access; ack arrives in the last of `waits` WAIT cycles.
  task automatic xfer(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] rdat, input int waits, input int exp_stalls,
                      input logic [7:0] exp_be, input logic [31:0] exp_addr,
                      input logic [63:0] exp_wd, input logic [63:0] exp_wm,
                      input logic [63:0] exp_rd);
    int stalls = 0;
    @(negedge clk);
    memreadM = rd; memwriteM = wr; sizeM = sz; signedM = sg; addrM = a; wdataM = wd; mem_rdata = rdat;
    #1 stalls += int'(stallM);
    chk({tag, "_req_idle"}, {63'd0, mem_req}, 64'd0);
    for (int i = 1; i <= waits; i++) begin
      @(negedge clk);
      stalls += int'(stallM);
      chk({tag, "_req"}, {63'd0, mem_req}, 64'd1);
      chk({tag, "_we"}, {63'd0, mem_we}, {63'd0, wr});
      chk({tag, "_be"}, {56'd0, mem_be}, {56'd0, exp_be});
      chk({tag, "_addr"}, {32'd0, mem_addr}, {32'd0, exp_addr});
      if (wr) chk({tag, "_wdata"}, mem_wdata & exp_wm, exp_wd);
      mem_ack = (i == waits);
    end
    @(negedge clk);
    mem_ack = 0;
    stalls += int'(stallM);
    chk({tag, "_done_stall"}, {63'd0, stallM}, 64'd0);
    chk({tag, "_done_req"}, {63'd0, mem_req}, 64'd0);
    chk({tag, "_done_be"}, {56'd0, mem_be}, 64'd0);
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    if (rd) chk({tag, "_rdata"}, rdataM, exp_rd);
    memreadM = 0; memwriteM = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_be", {56'd0, mem_be}, 64'd0);
    chk("rst_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_rdata", rdataM, 64'd0);
    chk("rst_misalign", {63'd0, misalign}, 64'd0);
    chk("rst_stall", {63'd0, stallM}, 64'd0);
    reset = 1;
    @(negedge clk);
    chk("idle_req", {63'd0, mem_req}, 64'd0);
    chk("idle_stall", {63'd0, stallM}, 64'd0);

    xfer("st_dword", 0, 1, 2'b11, 0, 64'h40, 64'h1122334455667788, 64'd0, 1, 2,
         8'hFF, 32'h40, 64'h1122334455667788, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    chk("st_no_rdata", rdataM, 64'd0);
    xfer("st_byte", 0, 1, 2'b00, 0, 64'h45, 64'hAB, 64'd0, 1, 2,
         8'h20, 32'h40, 64'h0000_AB00_0000_0000, 64'h0000_FF00_0000_0000, 64'd0);
    xfer("ld_half_s", 1, 0, 2'b01, 1, 64'h44, 64'd0, 64'h0000_80FF_0000_0000, 1, 2,
         8'h30, 32'h40, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_80FF);
    chk("ld_half_s_hold", rdataM, 64'hFFFF_FFFF_FFFF_80FF);
    xfer("ld_half_u", 1, 0, 2'b01, 0, 64'h44, 64'd0, 64'h0000_80FF_0000_0000, 1, 2,
         8'h30, 32'h40, 64'd0, 64'd0, 64'h0000_0000_0000_80FF);

    @(negedge clk);
    memreadM = 1; sizeM = 2'b10; signedM = 0; addrM = 64'h42;
    #1 chk("mis_stall0", {63'd0, stallM}, 64'd0);
    @(negedge clk);
    chk("mis_pulse", {63'd0, misalign}, 64'd1);
    chk("mis_req", {63'd0, mem_req}, 64'd0);
    chk("mis_stall1", {63'd0, stallM}, 64'd0);
    memreadM = 0;
    @(negedge clk);
    chk("mis_pulse_end", {63'd0, misalign}, 64'd0);
    chk("mis_req_end", {63'd0, mem_req}, 64'd0);
    chk("mis_rdata_hold", rdataM, 64'h0000_0000_0000_80FF);

    xfer("ld_byte_slow", 1, 0, 2'b00, 1, 64'h47, 64'd0, 64'h7F80_0000_0000_00FF, 5, 6,
         8'h80, 32'h40, 64'd0, 64'd0, 64'h0000_0000_0000_007F);
    xfer("ld_word_s", 1, 0, 2'b10, 1, 64'h40, 64'd0, 64'h1234_5678_8765_4321, 2, 3,
         8'h0F, 32'h40, 64'd0, 64'd0, 64'hFFFF_FFFF_8765_4321);
    xfer("ld_dword", 1, 0, 2'b11, 1, 64'h1_0000_0048, 64'd0, 64'h8000_0000_0000_0001, 1, 2,
         8'hFF, 32'h48, 64'd0, 64'd0, 64'h8000_0000_0000_0001);

    @(negedge clk);
    memreadM = 1; sizeM = 2'b10; signedM = 0; addrM = 64'h40;
    @(negedge clk);
    chk("rw_req", {63'd0, mem_req}, 64'd1);
    chk("rw_stall", {63'd0, stallM}, 64'd1);
    #2 reset = 0;
    #1 chk("rw_req_async", {63'd0, mem_req}, 64'd0);
    chk("rw_stall_rst", {63'd0, stallM}, 64'd0);
    chk("rw_be_rst", {56'd0, mem_be}, 64'd0);
    memreadM = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    chk("late_ack_rdata", rdataM, 64'd0);
    chk("late_ack_stall", {63'd0, stallM}, 64'd0);
    chk("late_ack_req", {63'd0, mem_req}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
